// File: rtl/fir_decimate_out.sv
// Decimating output stage for a 31-tap FIR: rounds/saturates the filter result to 8 bits,
// keeps every DECIM-th sample and queues it in a small show-ahead FIFO.
module fir_decimate_out #(
  parameter int unsigned DECIM = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     ready_in,
  input  logic [17:0]              y_in,
  output logic [7:0]               sample_out,
  output logic                     valid_out,
  input  logic                     ready_out_in,
  output logic [$clog2(DEPTH):0]   count_out,
  output logic                     overflow_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [PW-1:0] phase;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    mem [DEPTH];

  logic signed [18:0] biased_c;
  logic signed [8:0]  shifted_c;
  logic [7:0]         conv_c;
  logic               push_c;
  logic               pop_c;
  logic               full_c;
  logic               wr_c;
  logic [AW-1:0]      rd_next_c;
  logic [AW-1:0]      wr_next_c;
  logic [CW-1:0]      count_next_c;
  logic [CW-1:0]      after_pop_c;
  logic [PW-1:0]      phase_next_c;
  logic [7:0]         head_next_c;

  // Round half toward +inf via the +512 bias, then clamp to the signed 8-bit range.
  always_comb begin
    biased_c  = $signed({y_in[17], y_in}) + 19'sd512;
    shifted_c = 9'(biased_c >>> 10);
    if (shifted_c > 9'sd127)       conv_c = 8'h7F;
    else if (shifted_c < -9'sd128) conv_c = 8'h80;
    else                           conv_c = shifted_c[7:0];
  end

  always_comb begin
    push_c       = ready_in && (phase == '0);
    pop_c        = valid_out && ready_out_in;
    full_c       = (count_out == CW'(DEPTH));
    // A full FIFO only accepts a push when a pop frees a slot in the same cycle.
    wr_c         = push_c && (!full_c || pop_c);
    rd_next_c    = pop_c ? rd_ptr + AW'(1) : rd_ptr;
    wr_next_c    = wr_c ? wr_ptr + AW'(1) : wr_ptr;
    after_pop_c  = count_out - CW'(pop_c);
    count_next_c = after_pop_c + CW'(wr_c);
    phase_next_c = phase;
    if (ready_in) phase_next_c = (phase == PW'(DECIM - 1)) ? '0 : phase + PW'(1);
    // Registered head: a write into an otherwise empty FIFO bypasses the memory.
    head_next_c = sample_out;
    if (wr_c && (after_pop_c == '0)) head_next_c = conv_c;
    else if (count_next_c != '0)     head_next_c = mem[rd_next_c];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      phase        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_out    <= '0;
      valid_out    <= 1'b0;
      sample_out   <= '0;
      overflow_out <= 1'b0;
    end else begin
      phase        <= phase_next_c;
      wr_ptr       <= wr_next_c;
      rd_ptr       <= rd_next_c;
      count_out    <= count_next_c;
      valid_out    <= (count_next_c != '0);
      sample_out   <= head_next_c;
      if (push_c && full_c && !pop_c) overflow_out <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && wr_c) mem[wr_ptr] <= conv_c;
  end

endmodule

// File: doc/fir_decimate_out.md
FIR_DECIMATE_OUT -- requirements
Module: fir_decimate_out

Interface
REQ-001: Parameter DECIM, default 8, SHALL set the decimation factor (legal 1..32).
REQ-002: Parameter DEPTH, default 4, SHALL set the output FIFO depth in entries (power of two, 2..16).
REQ-003: clk_in  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004: rst_in  input  1  SHALL be the synchronous, active-high reset, sampled on the rising edge of clk_in.
REQ-005: ready_in  input  1  SHALL be the one-cycle sample strobe shared with the upstream 31-tap FIR filter.
REQ-006: y_in  input  18  SHALL be the FIR result, signed, scaled by 2**10, held stable from one ready_in to the next.
REQ-007: sample_out  output  8  SHALL be the signed decimated sample at the FIFO head.
REQ-008: valid_out  output  1  SHALL be high while the FIFO holds at least one entry.
REQ-009: ready_out_in  input  1  SHALL be the consumer accept signal; a transfer occurs when valid_out and ready_out_in are both high.
REQ-010: count_out  output  $clog2(DEPTH)+1  SHALL report the current FIFO occupancy.
REQ-011: overflow_out  output  1  SHALL be a sticky flag set when a decimated sample is dropped.

Function
REQ-012: Conversion SHALL be combinational on y_in: the 19-bit sum (y_in + 512), arithmetic right shift 10, saturated to [-128, +127].
REQ-013: Ties SHALL round toward +infinity (the +512 bias); no other rounding mode SHALL be applied.
REQ-014: A phase counter, range 0..DECIM-1, SHALL advance by 1 on every ready_in and wrap from DECIM-1 to 0.
REQ-015: On ready_in with phase == 0, the converted sample SHALL be pushed into the FIFO.
REQ-016: On ready_in with phase != 0, the FIFO SHALL be unchanged.
REQ-017: With DECIM = 1, every ready_in SHALL push a sample.
REQ-018: Latency SHALL be one cycle: a sample pushed on cycle N is visible at sample_out, with valid_out high, on cycle N+1 when the FIFO was empty.
REQ-019: The FIFO SHALL be show-ahead: sample_out presents the oldest entry whenever valid_out is high.
REQ-020: sample_out SHALL hold its value while valid_out is high and ready_out_in is low.
REQ-021: Pop SHALL occur on a cycle with valid_out and ready_out_in both high; the next entry, if any, appears the following cycle.
REQ-022: Push when full with no pop that cycle SHALL drop the new sample, set overflow_out, and leave the FIFO contents unchanged.
REQ-023: Push and pop in the same cycle when full SHALL both complete, leaving count_out unchanged and overflow_out unchanged.
REQ-024: Push and pop in the same cycle at any other non-empty occupancy SHALL leave count_out unchanged.
REQ-025: ready_out_in while valid_out is low SHALL be ignored.
REQ-026: Read and write pointers SHALL wrap modulo DEPTH; count_out SHALL range 0..DEPTH.
REQ-027: overflow_out SHALL remain high until rst_in.
REQ-028: The phase counter SHALL keep counting while the FIFO is full, so drops do not shift the decimation grid.

Reset
REQ-029: While rst_in is high: phase = 0, pointers = 0, count_out = 0, valid_out = 0, sample_out = 0, overflow_out = 0.
REQ-030: rst_in SHALL override ready_in and ready_out_in on the same cycle; a mid-operation reset discards all FIFO contents.
REQ-031: The first ready_in after reset deasserts SHALL be phase 0 and SHALL be pushed.

Verification
REQ-032: DECIM=8, y_in=0x00400 (1024), one ready_in after reset -> next cycle valid_out=1, sample_out=1, count_out=1.
REQ-033: Rounding and saturation:
- y_in=0x1FFFF -> sample_out=127
- y_in=0x20000 -> -128
- y_in=511 -> 0
- y_in=512 -> 1
- y_in=-513 -> -1
- y_in=-512 -> 0
REQ-034: DECIM=8, 24 ready_in strobes with ready_out_in=1 -> exactly 3 pushes, at strobes 1, 9 and 17.
REQ-035: DEPTH=4, DECIM=1, ready_out_in=0, 5 strobes with values 1..5 -> count_out=4, overflow_out=1, drained order 1,2,3,4.
REQ-036: FIFO full, ready_in push coincident with a pop -> count_out stays 4, overflow_out stays 0, new value appears last.
REQ-037: rst_in asserted for 1 cycle with count_out=3 -> next cycle valid_out=0, count_out=0, overflow_out=0; next strobe is pushed.
